// File: rtl/io_panel.sv
// io_panel: eight 16-bit display slots scanned onto an 8-digit multiplexed
// seven-segment display, plus two debounced switch banks for the processor.
module io_panel #(
  parameter int SCAN_DIV  = 1000,
  parameter int DB_CYCLES = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] outval1,
  input  logic [15:0] outval2,
  input  logic [2:0]  outsel,
  input  logic        outdisplay,
  input  logic [1:0]  page,
  input  logic [15:0] sw_a,
  input  logic [15:0] sw_b,
  output logic [15:0] inpval1,
  output logic [15:0] inpval2,
  output logic [7:0]  dig_n,
  output logic [7:0]  seg_n
);

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
  localparam int          DB_W      = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  // outval2 belongs to the OUT path but has no role on the panel.
  logic unused_outval2;
  assign unused_outval2 = ^outval2;

  logic [15:0] slot [8];
  logic [15:0] presc;
  logic [2:0]  idx;
  logic [2:0]  slot_sel;
  logic [15:0] shown;
  logic [3:0]  nib;
  logic [6:0]  glyph;

  // Slot registers: a strobe loads outval1 into the addressed slot.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: the slot array is cleared on reset so the panel shows zeros
    // straight away; this keeps it as flops rather than a RAM macro.
    if (!reset) begin
      for (int i = 0; i < 8; i++) slot[i] <= '0;
    end else if (outdisplay) begin
      slot[outsel] <= outval1;
    end
  end

  // Scan prescaler and digit index: index advances once per SCAN_DIV cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == SCAN_LAST) begin
      presc <= '0;
      idx   <= idx + 3'd1;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  // Pick the nibble for the current digit and decode it to segments.
  always_comb begin
    // NOTE: every output of this block is assigned on every path (the case
    // has a default), so no latch can be inferred.
    slot_sel = {page, idx[2]};
    shown    = slot[slot_sel];
    nib      = shown[{idx[1:0], 2'b00} +: 4];
    case (nib)
      4'h0:    glyph = 7'b1000000;
      4'h1:    glyph = 7'b1111001;
      4'h2:    glyph = 7'b0100100;
      4'h3:    glyph = 7'b0110000;
      4'h4:    glyph = 7'b0011001;
      4'h5:    glyph = 7'b0010010;
      4'h6:    glyph = 7'b0000010;
      4'h7:    glyph = 7'b1111000;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0010000;
      4'hA:    glyph = 7'b0001000;
      4'hB:    glyph = 7'b0000011;
      4'hC:    glyph = 7'b1000110;
      4'hD:    glyph = 7'b0100001;
      4'hE:    glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  end

  // Register digit enable and segments together so they switch on one edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dig_n <= 8'hFF;
      seg_n <= 8'hFF;
    end else begin
      dig_n <= ~(8'h01 << idx);
      seg_n <= {(idx != 3'd4), glyph};
    end
  end

  // Switch banks: index 0 is sw_a, index 1 is sw_b.
  logic [1:0][15:0]     raw, meta, sync, sync_q, stable;
  logic [1:0][DB_W-1:0] cnt;

  assign raw = {sw_b, sw_a};

  // Two-flop synchronizer, then per-bus debounce. A change of the synced
  // value while still differing restarts the count at one, so that a clean
  // step is accepted exactly DB_CYCLES+2 cycles after it hits the pins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta   <= '0;
      sync   <= '0;
      sync_q <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      meta   <= raw;
      sync   <= meta;
      sync_q <= sync;
      for (int b = 0; b < 2; b++) begin
        if (sync[b] == stable[b]) begin
          cnt[b] <= '0;
        end else if (sync[b] != sync_q[b]) begin
          cnt[b] <= DB_W'(1);
        end else if (cnt[b] == DB_LAST) begin
          stable[b] <= sync[b];
          cnt[b]    <= '0;
        end else begin
          cnt[b] <= cnt[b] + DB_W'(1);
        end
      end
    end
  end

  assign inpval1 = stable[0];
  assign inpval2 = stable[1];

endmodule

// File: tb/tb_io_panel.sv
// Directed bench for io_panel: one fast-scan instance (SCAN_DIV=1) for
// display contents and one slow-scan instance (SCAN_DIV=4) for scan timing.
module tb_io_panel;

  logic        clock;
  logic        reset;
  logic [15:0] outval1, outval2;
  logic [2:0]  outsel;
  logic        outdisplay;
  logic [1:0]  page;
  logic [15:0] sw_a, sw_b;

  logic [15:0] fast_in1, fast_in2, slow_in1, slow_in2;
  logic [7:0]  fast_dig, fast_seg, slow_dig, slow_seg;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  io_panel #(.SCAN_DIV(1), .DB_CYCLES(8)) u_fast (
    .clock(clock), .reset(reset), .outval1(outval1), .outval2(outval2),
    .outsel(outsel), .outdisplay(outdisplay), .page(page),
    .sw_a(sw_a), .sw_b(sw_b), .inpval1(fast_in1), .inpval2(fast_in2),
    .dig_n(fast_dig), .seg_n(fast_seg)
  );

  io_panel #(.SCAN_DIV(4), .DB_CYCLES(8)) u_slow (
    .clock(clock), .reset(reset), .outval1(outval1), .outval2(outval2),
    .outsel(outsel), .outdisplay(outdisplay), .page(page),
    .sw_a(sw_a), .sw_b(sw_b), .inpval1(slow_in1), .inpval2(slow_in2),
    .dig_n(slow_dig), .seg_n(slow_seg)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    check(tag, {8'h00, obs}, {8'h00, exp});
  endtask

  // Advance one clock edge and sample 1 ns later.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  logic [7:0] exp_dig;
  logic [7:0] seg_a[5]  = '{8'h8E, 8'h88, 8'hA4, 8'hF9, 8'h40};
  logic [7:0] seg_b[8]  = '{8'hA4, 8'hA4, 8'hA4, 8'hA4, 8'h40, 8'hC0, 8'hC0, 8'h80};

  initial begin
    reset = 1'b0; outval1 = '0; outval2 = '0; outsel = '0;
    outdisplay = 1'b0; page = 2'd0; sw_a = '0; sw_b = '0;

    // Held in reset: display dark, switches zero.
    repeat (3) @(posedge clock);
    #1;
    check8("rst_fast_dig", fast_dig, 8'hFF);
    check8("rst_fast_seg", fast_seg, 8'hFF);
    check8("rst_slow_dig", slow_dig, 8'hFF);
    check("rst_inpval1", fast_in1, 16'h0000);

    // First edge after release: digit 0 showing "0".
    reset = 1'b1;
    tick();
    check8("first_fast_dig", fast_dig, 8'hFE);
    check8("first_fast_seg", fast_seg, 8'hC0);
    check8("first_slow_dig", slow_dig, 8'hFE);
    check8("first_slow_seg", slow_seg, 8'hC0);

    // Write 12AF into slot 0, outval2 noise must not matter.
    outdisplay = 1'b1; outsel = 3'd0; outval1 = 16'h12AF; outval2 = 16'hDEAD;
    tick();
    outdisplay = 1'b0; outval2 = 16'h0000;
    while (cyc < 8) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check8($sformatf("hex12AF_dig%0d", i), fast_dig, 8'hFF ^ (8'h01 << i));
      check8($sformatf("hex12AF_seg%0d", i), fast_seg, seg_a[i]);
    end

    // slot3=8000, then back-to-back slot2 writes 1111/2222, then page 1.
    outdisplay = 1'b1; outsel = 3'd3; outval1 = 16'h8000;
    tick();
    outsel = 3'd2; outval1 = 16'h1111;
    tick();
    outval1 = 16'h2222;
    tick();
    outdisplay = 1'b0; page = 2'd1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check8($sformatf("page1_dig%0d", i), fast_dig, 8'hFF ^ (8'h01 << i));
      check8($sformatf("page1_seg%0d", i), fast_seg, seg_b[i]);
    end

    // Write to the slot whose digit is shown on the very next edge.
    while (cyc < 31) tick();
    outdisplay = 1'b1; outsel = 3'd2; outval1 = 16'h0005;
    tick();
    outdisplay = 1'b0;
    tick();
    check8("wr_next_dig", fast_dig, 8'hFE);
    check8("wr_next_seg", fast_seg, 8'h92);
    page = 2'd0;
    tick();
    check8("page_chg_dig", fast_dig, 8'hFD);
    check8("page_chg_seg", fast_seg, 8'h88);

    // Slow scan: each digit held four cycles, strictly one-hot.
    for (int n = 0; n < 40; n++) begin
      tick();
      exp_dig = 8'hFF ^ (8'h01 << (((cyc - 1) / 4) % 8));
      check8($sformatf("scan4_dig_c%0d", cyc), slow_dig, exp_dig);
      check($sformatf("scan4_onehot_c%0d", cyc), 16'($countones(~slow_dig)), 16'd1);
    end

    // Clean step on sw_a: accepted exactly 10 cycles later.
    sw_a = 16'h00FF;
    repeat (9) tick();
    check("db_step_early", fast_in1, 16'h0000);
    tick();
    check("db_step_fast", fast_in1, 16'h00FF);
    check("db_step_slow", slow_in1, 16'h00FF);
    check("db_step_in2", fast_in2, 16'h0000);

    // Five-cycle glitch back to zero must be rejected.
    sw_a = 16'h0000;
    repeat (5) tick();
    sw_a = 16'h00FF;
    repeat (20) tick();
    check("db_glitch", fast_in1, 16'h00FF);

    // Glitch to a different value and back before acceptance: rejected.
    sw_a = 16'h0F0F;
    repeat (4) tick();
    sw_a = 16'hF0F0;
    repeat (4) tick();
    sw_a = 16'h00FF;
    repeat (20) tick();
    check("db_restart", fast_in1, 16'h00FF);

    // Reset asserted mid-scan with sw_b debounce in progress.
    sw_b = 16'h1234;
    repeat (5) tick();
    check("db_b_pending", fast_in2, 16'h0000);
    reset = 1'b0;
    #1;
    check8("async_fast_dig", fast_dig, 8'hFF);
    check8("async_fast_seg", fast_seg, 8'hFF);
    check8("async_slow_dig", slow_dig, 8'hFF);
    check8("async_slow_seg", slow_seg, 8'hFF);
    check("async_inpval1", fast_in1, 16'h0000);
    check("async_inpval2", fast_in2, 16'h0000);
    tick();
    reset = 1'b1;
    tick();
    check8("post_rst_dig", fast_dig, 8'hFE);
    check8("post_rst_seg", fast_seg, 8'hC0);
    check("post_rst_inpval2", fast_in2, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
